// File: rtl/tone_period_decoder.sv
// Identifies the note on a square-wave tone line by measuring the rising-edge period,
// classifying it against five nominal periods, debouncing, and detecting silence.
//
// state     | meaning
// S_IDLE    | no reference edge yet; the next edge starts a measurement
// S_MEASURE | counting between edges; each edge latches a period for classification
// S_SILENT  | no edge for SILENCE_CYCLES; clears the note and candidate, then idles
module tone_period_decoder #(
  parameter int unsigned P_E3           = 606760,
  parameter int unsigned P_G3           = 510204,
  parameter int unsigned P_A3           = 454546,
  parameter int unsigned P_C4           = 382220,
  parameter int unsigned P_E4           = 303370,
  parameter int unsigned TOL_SHIFT      = 6,
  parameter int unsigned CONFIRM        = 2,
  parameter int unsigned SILENCE_CYCLES = 1000000,
  parameter int unsigned CNT_W          = 20
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             tone_in,
  output logic [2:0]       note_code,
  output logic             note_valid,
  output logic             note_change,
  output logic [CNT_W-1:0] period_out,
  output logic [7:0]       onset_count
);

  typedef enum logic [1:0] {S_IDLE, S_MEASURE, S_SILENT} state_t;

  localparam logic [2:0] C_NONE    = 3'd0;
  localparam logic [2:0] C_E3      = 3'd1;
  localparam logic [2:0] C_G3      = 3'd2;
  localparam logic [2:0] C_A3      = 3'd3;
  localparam logic [2:0] C_C4      = 3'd4;
  localparam logic [2:0] C_E4      = 3'd5;
  localparam logic [2:0] C_UNKNOWN = 3'd7;

  localparam logic [2:0]       CONF_MAX = 3'(CONFIRM);
  localparam logic [CNT_W-1:0] SIL      = CNT_W'(SILENCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};

  localparam logic [CNT_W-1:0] LO_E3 = CNT_W'(P_E3 - (P_E3 >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] HI_E3 = CNT_W'(P_E3 + (P_E3 >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] LO_G3 = CNT_W'(P_G3 - (P_G3 >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] HI_G3 = CNT_W'(P_G3 + (P_G3 >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] LO_A3 = CNT_W'(P_A3 - (P_A3 >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] HI_A3 = CNT_W'(P_A3 + (P_A3 >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] LO_C4 = CNT_W'(P_C4 - (P_C4 >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] HI_C4 = CNT_W'(P_C4 + (P_C4 >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] LO_E4 = CNT_W'(P_E4 - (P_E4 >> TOL_SHIFT));
  localparam logic [CNT_W-1:0] HI_E4 = CNT_W'(P_E4 + (P_E4 >> TOL_SHIFT));

  function automatic logic [2:0] classify(input logic [CNT_W-1:0] p);
    logic [2:0] c;
    c = C_UNKNOWN;
    if      (p >= LO_E3 && p <= HI_E3) c = C_E3;
    else if (p >= LO_G3 && p <= HI_G3) c = C_G3;
    else if (p >= LO_A3 && p <= HI_A3) c = C_A3;
    else if (p >= LO_C4 && p <= HI_C4) c = C_C4;
    else if (p >= LO_E4 && p <= HI_E4) c = C_E4;
    return c;
  endfunction

  state_t           state_q, state_d;
  logic             sync0_q, sync1_q, sync2_q;
  logic             edge_w;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] period_q, period_d;
  logic             cls_v_q, cls_v_d;
  logic [2:0]       cand_q, cand_d;
  logic [2:0]       conf_q, conf_d;
  logic             upd_q, upd_d;
  logic [2:0]       code_q, code_d;
  logic             valid_q;
  logic             change_q, change_d;
  logic [7:0]       onset_q, onset_d;
  logic [2:0]       cls_w;

  assign edge_w = sync1_q & ~sync2_q;
  assign cls_w  = classify(period_q);

  always_comb begin
    state_d  = state_q;
    period_d = period_q;
    cls_v_d  = 1'b0;
    cand_d   = cand_q;
    conf_d   = conf_q;
    upd_d    = 1'b0;
    code_d   = code_q;
    change_d = 1'b0;
    onset_d  = onset_q;

    if (edge_w)                cnt_d = {{(CNT_W-1){1'b0}}, 1'b1};
    else if (cnt_q == CNT_MAX) cnt_d = cnt_q;
    else                       cnt_d = cnt_q + 1'b1;

    // Debounce stage, one cycle after the period was latched
    if (cls_v_q) begin
      upd_d = 1'b1;
      if (cls_w == cand_q) begin
        conf_d = (conf_q >= CONF_MAX) ? CONF_MAX : conf_q + 3'd1;
      end else begin
        cand_d = cls_w;
        conf_d = 3'd1;
      end
    end

    // Report stage, one cycle after the debounce stage
    if (upd_q && conf_q == CONF_MAX && cand_q != code_q) begin
      code_d   = cand_q;
      change_d = 1'b1;
      if (code_q == C_NONE) onset_d = onset_q + 8'd1;
    end

    case (state_q)
      S_IDLE: begin
        if (edge_w) state_d = S_MEASURE;
      end
      S_MEASURE: begin
        if (edge_w) begin
          period_d = cnt_q;
          cls_v_d  = 1'b1;
        end else if (cnt_q == SIL) begin
          state_d = S_SILENT;
        end
      end
      S_SILENT: begin
        // An edge landing here becomes the new reference rather than being lost
        state_d = edge_w ? S_MEASURE : S_IDLE;
        cand_d  = C_NONE;
        conf_d  = 3'd0;
        upd_d   = 1'b0;
        if (code_q != C_NONE) begin
          code_d   = C_NONE;
          change_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_IDLE;
      sync0_q  <= 1'b0;
      sync1_q  <= 1'b0;
      sync2_q  <= 1'b0;
      cnt_q    <= '0;
      period_q <= '0;
      cls_v_q  <= 1'b0;
      cand_q   <= C_NONE;
      conf_q   <= 3'd0;
      upd_q    <= 1'b0;
      code_q   <= C_NONE;
      valid_q  <= 1'b0;
      change_q <= 1'b0;
      onset_q  <= 8'd0;
    end else begin
      state_q  <= state_d;
      sync0_q  <= tone_in;
      sync1_q  <= sync0_q;
      sync2_q  <= sync1_q;
      cnt_q    <= cnt_d;
      period_q <= period_d;
      cls_v_q  <= cls_v_d;
      cand_q   <= cand_d;
      conf_q   <= conf_d;
      upd_q    <= upd_d;
      code_q   <= code_d;
      valid_q  <= (code_d != C_NONE);
      change_q <= change_d;
      onset_q  <= onset_d;
    end
  end

  assign note_code   = code_q;
  assign note_valid  = valid_q;
  assign note_change = change_q;
  assign period_out  = period_q;
  assign onset_count = onset_q;

endmodule

// File: tb/tb_tone_period_decoder.sv
// Directed bench for tone_period_decoder with periods scaled down ~1000x so runs stay short;
// expected note changes are queued at stimulus time and matched when note_change fires.
module tb_tone_period_decoder;

  localparam int P_E3  = 607;
  localparam int P_G3  = 510;
  localparam int P_A3  = 455;
  localparam int P_C4  = 382;
  localparam int P_E4  = 303;
  localparam int TOLS  = 6;
  localparam int CONF  = 2;
  localparam int SIL   = 1000;
  localparam int CNT_W = 11;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             tone_in = 1'b0;
  logic [2:0]       note_code;
  logic             note_valid;
  logic             note_change;
  logic [CNT_W-1:0] period_out;
  logic [7:0]       onset_count;

  tone_period_decoder #(
    .P_E3(P_E3), .P_G3(P_G3), .P_A3(P_A3), .P_C4(P_C4), .P_E4(P_E4),
    .TOL_SHIFT(TOLS), .CONFIRM(CONF), .SILENCE_CYCLES(SIL), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .reset(reset), .tone_in(tone_in),
    .note_code(note_code), .note_valid(note_valid), .note_change(note_change),
    .period_out(period_out), .onset_count(onset_count)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc++;

  typedef struct { int code; int at; } exp_t;
  exp_t sb[$];

  int n_tests = 0;
  int n_fail = 0;
  int n_changes = 0;
  int rise_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Scoreboard side: every note_change must match the oldest queued expectation
  always @(negedge clk) begin
    if (!reset && note_change) begin
      exp_t e;
      n_changes++;
      check("change_expected", 32'(sb.size() != 0), 32'd1);
      if (sb.size() != 0) begin
        e = sb.pop_front();
        check("change_code", 32'(note_code), e.code);
        check("change_valid", 32'(note_valid), 32'(e.code != 0));
        check("change_cycle", cyc, e.at);
      end
    end
  end

  // One tone period starting with a rising edge; optionally queue the change that edge confirms.
  // A change lands 5 negedge samples after the rise is driven (2 sync, edge, classify, report).
  task automatic tone(input int p, input int exp_code);
    @(negedge clk);
    tone_in = 1'b1;
    rise_cyc = cyc;
    if (exp_code >= 0) sb.push_back('{exp_code, cyc + 5});
    repeat (p / 2) @(negedge clk);
    tone_in = 1'b0;
    repeat (p - p / 2 - 1) @(negedge clk);
  endtask

  task automatic tones(input int p, input int n);
    for (int i = 0; i < n; i++) tone(p, -1);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_code"}, 32'(note_code), 32'd0);
    check({tag, "_valid"}, 32'(note_valid), 32'd0);
    check({tag, "_change"}, 32'(note_change), 32'd0);
    check({tag, "_period"}, 32'(period_out), 32'd0);
    check({tag, "_onset"}, 32'(onset_count), 32'd0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    tone_in = 1'b0;
    repeat (4) @(negedge clk);
    check_zero("reset");
    reset = 1'b0;
  endtask

  task automatic settle(input string tag, input int code, input int period, input int onset);
    check({tag, "_code"}, 32'(note_code), code);
    check({tag, "_valid"}, 32'(note_valid), 32'(code != 0));
    check({tag, "_period"}, 32'(period_out), period);
    check({tag, "_onset"}, 32'(onset_count), onset);
    check({tag, "_sb_drained"}, sb.size(), 32'd0);
  endtask

  int base;
  int tol_p[3]    = '{P_E4 + 4, P_E4 + 5, P_E4 - 4};
  int tol_code[3] = '{5, 7, 5};

  initial begin
    // A3 steady: change confirmed on the 3rd rising edge
    do_reset();
    base = n_changes;
    tone(P_A3, -1);
    tone(P_A3, -1);
    tone(P_A3, 3);
    tone(P_A3, -1);
    settle("a3", 3, P_A3, 1);
    check("a3_changes", n_changes - base, 1);

    // A3 -> G3 -> C4 back to back; each switch reports two edges later
    do_reset();
    base = n_changes;
    tone(P_A3, -1); tone(P_A3, -1); tone(P_A3, 3); tone(P_A3, -1);
    tone(P_G3, -1); tone(P_G3, -1); tone(P_G3, 2); tone(P_G3, -1);
    tone(P_C4, -1); tone(P_C4, -1); tone(P_C4, 4); tone(P_C4, -1);
    settle("seq", 4, P_C4, 1);
    check("seq_changes", n_changes - base, 3);

    // Tolerance boundaries around E4
    for (int i = 0; i < 3; i++) begin
      do_reset();
      tone(tol_p[i], -1);
      tone(tol_p[i], -1);
      tone(tol_p[i], tol_code[i]);
      tone(tol_p[i], -1);
      settle($sformatf("tol%0d", i), tol_code[i], tol_p[i], 1);
    end

    // Staccato: silence declared SIL+4 samples after the last rise is driven
    do_reset();
    base = n_changes;
    tone(P_A3, -1);
    tone(P_A3, -1);
    tone(P_A3, 3);
    sb.push_back('{0, rise_cyc + SIL + 4});
    repeat (1200) @(negedge clk);
    check("stac_gap_code", 32'(note_code), 32'd0);
    check("stac_gap_valid", 32'(note_valid), 32'd0);
    tone(P_A3, -1);
    tone(P_A3, -1);
    tone(P_A3, 3);
    tone(P_A3, -1);
    settle("stac", 3, P_A3, 2);
    check("stac_changes", n_changes - base, 3);

    // Single short glitch period inside steady C4
    do_reset();
    tone(P_C4, -1); tone(P_C4, -1); tone(P_C4, 4); tone(P_C4, -1);
    base = n_changes;
    tone(250, -1);
    tone(P_C4, -1);
    check("glitch_period_short", 32'(period_out), 32'd250);
    tone(P_C4, -1);
    check("glitch_period_back", 32'(period_out), P_C4);
    tones(P_C4, 2);
    settle("glitch", 4, P_C4, 1);
    check("glitch_changes", n_changes - base, 0);

    // One-cycle reset in the low half of a steady E3, then re-acquire
    do_reset();
    tone(P_E3, -1); tone(P_E3, -1); tone(P_E3, 1); tone(P_E3, -1);
    check("e3_pre_code", 32'(note_code), 32'd1);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check_zero("midrst");
    reset = 1'b0;
    base = n_changes;
    tone(P_E3, -1);
    tone(P_E3, -1);
    tone(P_E3, 1);
    tone(P_E3, -1);
    settle("midrst_reacq", 1, P_E3, 1);
    check("midrst_changes", n_changes - base, 1);

    repeat (10) @(negedge clk);
    check("final_sb_drained", sb.size(), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
